// File: rtl/ram_capture_ctrl_pkg.sv
// ram_capture_pkg: shared types and default sizing for the RAM capture
// sequencer.
//   state_t        capture FSM states
//   *_DEF          default build parameters
//   DEPTH          RAM depth for the default address width
//   POST_DEPTH     samples written from the trigger onward, trigger included
//   post_depth()   the same quantity for any width / pre-trigger depth
package ram_capture_pkg;

    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRE_DEPTH_DEF  = 256;

    localparam int DEPTH      = 2 ** ADDR_WIDTH_DEF;
    localparam int POST_DEPTH = DEPTH - PRE_DEPTH_DEF;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        READ
    } state_t;

    function automatic int post_depth(input int aw, input int pre);
        return (2 ** aw) - pre;
    endfunction

endpackage

// File: rtl/ram_capture_ctrl_if.sv
// ram_capture_ctrl_if: readout stream towards the downstream formatter.
//   dout        sample
//   dout_valid  beat valid
//   dout_ready  sink ready
//   dout_last   final beat of the window
// master = capture controller, slave = formatter.
interface ram_capture_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  dout_last;

    modport master (output dout, output dout_valid, output dout_last, input dout_ready);
    modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/ram_capture_ofifo.sv
// ram_capture_ofifo: 2-entry valid/ready skid FIFO on the readout path.
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_push, i_data   write side (no back-pressure; the caller issues on credit)
//   o_valid, o_data  head entry, held stable until accepted
//   i_ready          sink accept
//   o_occ            entries currently held (0..2)
module ram_capture_ofifo #(
    parameter int W = 9
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_occ
);
    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_occ;
    logic         w_pop;

    assign w_pop   = (r_occ != 2'd0) && i_ready;
    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_occ   = r_occ;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + 2'(i_push) - 2'(w_pop);
        end
    end
endmodule

// File: rtl/ram_capture_ctrl.sv
// ram_capture_ctrl: pre/post-trigger capture sequencer for a 2^ADDR_WIDTH x
// DATA_WIDTH simple dual-port RAM, then oldest-first readout of the window.
//   i_clk, i_rst_n        clock (shared with the RAM), synchronous active-low reset
//   i_arm                 start pulse, honoured only when idle
//   i_trig                trigger input
//   i_din, i_din_valid    sample stream
//   o_ram_wr_*            registered RAM write port
//   o_ram_rd_addr         RAM read address; i_ram_rd_data returns 1 cycle later
//   m_out                 readout stream (dout/valid/ready/last)
//   o_busy                high outside IDLE
//   o_done                1-cycle pulse after the last beat is accepted
//   o_trig_addr           RAM address of the trigger sample
// Build option: define TRIG_EDGE_EN to trigger on a rising edge of i_trig
// instead of on the level.
module ram_capture_ctrl
    import ram_capture_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRE_DEPTH  = PRE_DEPTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_arm,
    input  logic                  i_trig,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_din_valid,
    output logic                  o_ram_wr_en,
    output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wr_data,
    output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
    ram_capture_ctrl_if.master    m_out,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_trig_addr
);
    localparam int CW     = ADDR_WIDTH + 1;
    localparam int L_DEPTH = 2 ** ADDR_WIDTH;
    localparam int L_POST  = post_depth(ADDR_WIDTH, PRE_DEPTH);

    localparam logic [CW-1:0]         C_PRE_LAST  = CW'(PRE_DEPTH - 1);
    localparam logic [CW-1:0]         C_POST_LAST = CW'(L_POST - 1);
    localparam logic [CW-1:0]         C_DEPTH     = CW'(L_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] A_PRE       = ADDR_WIDTH'(PRE_DEPTH);

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_rem;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_trig_addr;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_trig_cond;
    logic                  w_trig_hit;
    logic                  w_issue;
    logic                  w_pop;
    logic [2:0]            w_credit;
    logic                  w_fifo_valid;
    logic [DATA_WIDTH:0]   w_fifo_data;
    logic [1:0]            w_occ;

`ifdef TRIG_EDGE_EN
    logic r_trig_prev;
    assign w_trig_cond = i_trig && !r_trig_prev;
`else
    assign w_trig_cond = i_trig;
`endif

    assign w_accept   = i_din_valid &&
                        (r_state == PRE || r_state == ARMED || r_state == POST);
    assign w_trig_hit = (r_state == ARMED) && i_din_valid && w_trig_cond;

    // Slots already claimed: held entries plus the read in flight, minus
    // the entry leaving this cycle. Never underflows since a pop implies occ>=1.
    assign w_pop    = w_fifo_valid && m_out.dout_ready;
    assign w_credit = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue  = (r_state == READ) && (r_rem != '0) && (w_credit < 3'd2);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_rem           <= '0;
            r_wr_ptr        <= '0;
            r_rd_addr       <= '0;
            r_trig_addr     <= '0;
            r_wr_en         <= 1'b0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
`ifdef TRIG_EDGE_EN
            r_trig_prev     <= 1'b0;
`endif
        end else begin
`ifdef TRIG_EDGE_EN
            r_trig_prev <= i_trig;
`endif
            r_done  <= 1'b0;
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= r_wr_ptr;
                r_wr_data <= i_din;
                r_wr_ptr  <= r_wr_ptr + 1'b1;
            end

            // The issued read lands in the FIFO next cycle with its last flag.
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rem == CW'(1));
            if (w_issue) begin
                r_rd_addr <= r_rd_addr + 1'b1;
                r_rem     <= r_rem - 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_wr_ptr <= '0;
                    r_cnt    <= '0;
                    if (i_arm) begin
                        r_state <= PRE;
                    end
                end
                PRE: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_PRE_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (w_trig_hit) begin
                        r_trig_addr <= r_wr_ptr;
                        r_cnt       <= CW'(1);
                        if (L_POST == 1) begin
                            r_rd_addr <= r_wr_ptr - A_PRE;
                            r_rem     <= C_DEPTH;
                            r_state   <= READ;
                        end else begin
                            r_state <= POST;
                        end
                    end
                end
                POST: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_POST_LAST) begin
                            r_rd_addr <= r_trig_addr - A_PRE;
                            r_rem     <= C_DEPTH;
                            r_state   <= READ;
                        end
                    end
                end
                READ: begin
                    if (w_pop && w_fifo_data[DATA_WIDTH]) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ram_capture_ofifo #(
        .W(DATA_WIDTH + 1)
    ) u_ofifo (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_push (r_inflight),
        .i_data ({r_inflight_last, i_ram_rd_data}),
        .i_ready(m_out.dout_ready),
        .o_valid(w_fifo_valid),
        .o_data (w_fifo_data),
        .o_occ  (w_occ)
    );

    assign m_out.dout       = w_fifo_data[DATA_WIDTH-1:0];
    assign m_out.dout_valid = w_fifo_valid;
    assign m_out.dout_last  = w_fifo_valid && w_fifo_data[DATA_WIDTH];

    assign o_ram_wr_en   = r_wr_en;
    assign o_ram_wr_addr = r_wr_addr;
    assign o_ram_wr_data = r_wr_data;
    assign o_ram_rd_addr = r_rd_addr;
    assign o_busy        = (r_state != IDLE);
    assign o_done        = r_done;
    assign o_trig_addr   = r_trig_addr;
endmodule

// File: tb/tb_ram_capture_ctrl.sv
// Bench for ram_capture_ctrl: RAM model, scoreboard queue filled with the
// expected capture window, and a negedge monitor that pops on each handshake.
module tb_ram_capture_ctrl;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1024;
    localparam int PRE   = 256;
    localparam int POST  = 768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          arm = 1'b0;
    logic          trig = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          busy;
    logic          done;
    logic [AW-1:0] trig_addr;

    ram_capture_ctrl_if #(.DATA_WIDTH(DW)) dif ();

    ram_capture_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_arm        (arm),
        .i_trig       (trig),
        .i_din        (din),
        .i_din_valid  (din_valid),
        .o_ram_wr_en  (ram_wr_en),
        .o_ram_wr_addr(ram_wr_addr),
        .o_ram_wr_data(ram_wr_data),
        .o_ram_rd_addr(ram_rd_addr),
        .i_ram_rd_data(ram_rd_data),
        .m_out        (dif.master),
        .o_busy       (busy),
        .o_done       (done),
        .o_trig_addr  (trig_addr)
    );

    // Simple dual-port RAM with registered read.
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        ram_rd_data = '0;
    end
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } beat_t;
    beat_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int k, input int mode);
        int v;
        v = (mode == 0) ? k : (k * 37 + 5);
        return DW'(v & 255);
    endfunction

    // Ready driver.
    bit rnd_ready = 1'b0;
    initial begin
        dif.dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dif.dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor.
    bit            mon_en = 1'b0;
    int            cyc = 0;
    int            beats, first_hs, last_hs, done_cnt;
    bit            seen_valid, prev_stall, last_hs_flag;
    logic [AW-1:0] rd_at_first;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (last_hs_flag) begin
                    chk("done_after_last", 32'({done, busy}), 32'b10);
                    last_hs_flag = 1'b0;
                end
                if (done) done_cnt++;
                if (prev_stall)
                    chk("stall_hold", 32'({dif.dout_valid, dif.dout_last, dif.dout}),
                        32'({1'b1, prev_l, prev_d}));
                if (dif.dout_valid && !seen_valid) begin
                    seen_valid  = 1'b1;
                    rd_at_first = ram_rd_addr;
                end
                if (dif.dout_valid && dif.dout_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("beat_unexpected", 32'(dif.dout_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 32'(dif.dout), 32'(e.d));
                        chk("beat_last", 32'(dif.dout_last), 32'(e.last));
                    end
                    if (beats == 0) first_hs = cyc;
                    last_hs = cyc;
                    beats++;
                    if (dif.dout_last) last_hs_flag = 1'b1;
                end
                prev_stall = dif.dout_valid && !dif.dout_ready;
                prev_d     = dif.dout;
                prev_l     = dif.dout_last;
            end else begin
                prev_stall   = 1'b0;
                last_hs_flag = 1'b0;
            end
        end
    end

    task automatic clear_stats();
        beats = 0; first_hs = 0; last_hs = 0; done_cnt = 0;
        seen_valid = 1'b0; rd_at_first = '0;
        exp_q.delete();
    endtask

    task automatic arm_it();
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
    endtask

    // Sample k drives value pat(k); trig is high on sample t1/t2 or always.
    task automatic send_samples(input int n, input int t1, input int t2,
                                input bit hold, input int mode);
        for (int k = 0; k < n; k++) begin
            din_valid = 1'b1;
            din       = pat(k, mode);
            trig      = hold || (k == t1) || (k == t2);
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        trig      = 1'b0;
    endtask

    task automatic push_window(input int tk, input int mode);
        beat_t b;
        for (int k = tk - PRE; k < tk + POST; k++) begin
            b.d    = pat(k, mode);
            b.last = (k == tk + POST - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_done(input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("done_timeout", 32'(got), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_capture(input int tk, input int t2, input bit hold,
                               input int n, input int mode, input bit rnd);
        clear_stats();
        rnd_ready = rnd;
        mon_en    = 1'b1;
        push_window(tk, mode);
        arm_it();
        send_samples(n, hold ? -1 : tk, t2, hold, mode);
        chk("trig_addr", 32'(trig_addr), 32'(tk % DEPTH));
        wait_done(rnd ? 20000 : 4000);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("beat_count", 32'(beats), 32'(DEPTH));
        chk("busy_idle", 32'(busy), 32'd0);
        if (!rnd) begin
            chk("burst_span", 32'(last_hs - first_hs), 32'(DEPTH - 1));
            chk("rd_addr_first", 32'(rd_at_first), 32'((tk - PRE + 2) % DEPTH));
        end
        mon_en    = 1'b0;
        rnd_ready = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ctl"}, 32'({ram_wr_en, busy, done, dif.dout_valid, dif.dout_last}), 32'd0);
        chk({tag, "_addr"}, 32'({ram_wr_addr, ram_rd_addr, trig_addr}), 32'd0);
        chk({tag, "_data"}, 32'({ram_wr_data, dif.dout}), 32'd0);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Ramp, trigger at sample 600, ready high.
        run_capture(600, -1, 1'b0, 2000, 0, 1'b0);
        // Trigger during PRE ignored; next trigger at 700 taken.
        run_capture(700, 100, 1'b0, 700 + POST + 10, 0, 1'b0);
        // Random back-pressure, same capture as the first run.
        run_capture(600, -1, 1'b0, 2000, 0, 1'b1);
        // Trigger at address 1000: window wraps 1023 -> 0.
        run_capture(1000, -1, 1'b0, 1000 + POST + 10, 1, 1'b0);

        // Reset mid-readout.
        begin
            bit reached = 1'b0;
            clear_stats();
            mon_en = 1'b1;
            push_window(600, 0);
            arm_it();
            send_samples(600 + POST + 10, 600, -1, 1'b0, 0);
            for (int i = 0; i < 3000 && !reached; i++) begin
                @(negedge clk);
                if (beats >= 100) reached = 1'b1;
            end
            chk("midread_reach", 32'(reached), 32'd1);
            @(posedge clk); #1;
            mon_en = 1'b0;
            rst_n  = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1;
            @(negedge clk);
            check_zero_outputs("midreset");
            exp_q.delete();
        end
        run_capture(300, -1, 1'b0, 300 + POST + 10, 1, 1'b0);

        // Trigger held high from the start.
`ifdef TRIG_EDGE_EN
        clear_stats();
        mon_en = 1'b1;
        arm_it();
        send_samples(1500, -1, -1, 1'b1, 0);
        repeat (20) @(negedge clk);
        chk("hold_no_capture_busy", 32'(busy), 32'd1);
        chk("hold_no_readout", 32'(seen_valid), 32'd0);
        mon_en = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("hold_reset_idle", 32'(busy), 32'd0);
`else
        run_capture(PRE, -1, 1'b1, PRE + POST + 10, 0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
